// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: answers read (0x03/0x0B), JEDEC ID, status and
// power-down commands, fetching read data from an external fixed-latency memory.
module spi_flash_responder #(
    parameter logic [23:0] JEDEC_ID   = 24'hEF4018,
    parameter logic [7:0]  STATUS_VAL = 8'h00
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        spi_sck,
    input  logic        spi_cs,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic [23:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic        powered_down
);

    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_IGNORE} state_t;
    typedef enum logic [1:0] {SRC_MEM, SRC_ID, SRC_STATUS} src_t;

    logic [2:0]  sck_sync_q, cs_sync_q;
    logic [1:0]  mosi_sync_q;
    logic [1:0]  flush_q;
    logic        armed_q;

    state_t      state_q, state_d;
    src_t        src_q, src_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic [23:0] addr_q, addr_d;
    logic        fast_q, fast_d;
    logic [1:0]  id_idx_q, id_idx_d;
    logic [7:0]  tx_q, tx_d;
    logic        miso_q, miso_d;
    logic        oe_q, oe_d;
    logic        mem_rd_q, mem_rd_d;
    logic        load_q;
    logic        pd_q, pd_d;

    logic sck_rise, sck_fall, cs_fall, cs_rise, mosi_bit;
    logic [7:0] cmd_byte;

    // A CS fall only counts once CS has been seen high after reset, so a CS
    // held low across reset cannot start a command on its own.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sck_sync_q  <= 3'b000;
            cs_sync_q   <= 3'b111;
            mosi_sync_q <= 2'b00;
            flush_q     <= 2'd0;
            armed_q     <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[1:0], spi_sck};
            cs_sync_q   <= {cs_sync_q[1:0], spi_cs};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            if (flush_q != 2'd3) flush_q <= flush_q + 2'd1;
            if (flush_q == 2'd3 && cs_sync_q[1] && cs_sync_q[2]) armed_q <= 1'b1;
        end
    end

    assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
    assign cs_fall  = armed_q & ~cs_sync_q[1] & cs_sync_q[2];
    assign cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];
    assign mosi_bit = mosi_sync_q[1];
    assign cmd_byte = {shift_q, mosi_bit};

    function automatic logic [7:0] id_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = 8'hFF;
        endcase
    endfunction

    always_comb begin
        // NOTE: every next-state value defaults to its register first so no path infers a latch.
        state_d   = state_q;
        src_d     = src_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        addr_d    = mem_rd_q ? addr_q + 24'd1 : addr_q;
        fast_d    = fast_q;
        id_idx_d  = id_idx_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        oe_d      = oe_q;
        mem_rd_d  = 1'b0;
        pd_d      = pd_q;

        if (cs_rise) begin
            state_d   = ST_IDLE;
            oe_d      = 1'b0;
            bit_cnt_d = 5'd0;
        end else if (cs_fall) begin
            state_d   = ST_CMD;
            oe_d      = 1'b0;
            bit_cnt_d = 5'd0;
        end else begin
            case (state_q)
                ST_CMD: if (sck_rise) begin
                    shift_d   = cmd_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = 5'd0;
                        state_d   = ST_IGNORE;
                        if (!pd_q || cmd_byte == 8'hAB) begin
                            case (cmd_byte)
                                8'h03: begin state_d = ST_ADDR; fast_d = 1'b0; src_d = SRC_MEM; end
                                8'h0B: begin state_d = ST_ADDR; fast_d = 1'b1; src_d = SRC_MEM; end
                                8'h9F: begin
                                    state_d  = ST_DATA;
                                    src_d    = SRC_ID;
                                    tx_d     = id_byte(2'd0);
                                    id_idx_d = 2'd1;
                                end
                                8'h05: begin state_d = ST_DATA; src_d = SRC_STATUS; tx_d = STATUS_VAL; end
                                8'hB9: pd_d = 1'b1;
                                8'hAB: pd_d = 1'b0;
                                default: ;
                            endcase
                        end
                    end
                end
                ST_ADDR: if (sck_rise) begin
                    addr_d    = {addr_q[22:0], mosi_bit};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd23) begin
                        bit_cnt_d = 5'd0;
                        state_d   = fast_q ? ST_DUMMY : ST_DATA;
                        mem_rd_d  = ~fast_q;
                    end
                end
                ST_DUMMY: if (sck_rise) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = 5'd0;
                        state_d   = ST_DATA;
                        mem_rd_d  = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            case (src_q)
                                SRC_MEM: mem_rd_d = 1'b1;
                                SRC_ID: begin
                                    tx_d     = id_byte(id_idx_q);
                                    id_idx_d = (id_idx_q == 2'd3) ? 2'd3 : id_idx_q + 2'd1;
                                end
                                default: tx_d = STATUS_VAL;
                            endcase
                        end
                    end
                    if (sck_fall) begin
                        oe_d   = 1'b1;
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                    // Fetched byte lands two clk after the strobe, well before the next SCK fall.
                    if (load_q) tx_d = mem_rdata;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the reset branch covers every register here; none of this state is a memory array.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            src_q     <= SRC_MEM;
            bit_cnt_q <= 5'd0;
            shift_q   <= 7'd0;
            addr_q    <= 24'd0;
            fast_q    <= 1'b0;
            id_idx_q  <= 2'd0;
            tx_q      <= 8'd0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            mem_rd_q  <= 1'b0;
            load_q    <= 1'b0;
            pd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            fast_q    <= fast_d;
            id_idx_q  <= id_idx_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            mem_rd_q  <= mem_rd_d;
            load_q    <= mem_rd_q;
            pd_q      <= pd_d;
        end
    end

    assign spi_miso     = miso_q;
    assign spi_miso_oe  = oe_q;
    assign mem_addr     = addr_q;
    assign mem_rd       = mem_rd_q;
    assign powered_down = pd_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: a command-level model queues the
// expected MISO bytes and fetch addresses; monitors compare as the DUT produces them.
module tb_spi_flash_responder;

    localparam logic [23:0] JEDEC  = 24'hEF4018;
    localparam logic [7:0]  STATUS = 8'h00;

    logic        clk = 1'b0;
    logic        resetn, spi_sck, spi_cs, spi_mosi;
    logic        spi_miso, spi_miso_oe, mem_rd, powered_down;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  exp_miso[$];
    logic [23:0] exp_addr[$];
    bit          model_pd;

    spi_flash_responder #(.JEDEC_ID(JEDEC), .STATUS_VAL(STATUS)) dut (
        .clk(clk), .resetn(resetn), .spi_sck(spi_sck), .spi_cs(spi_cs),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .powered_down(powered_down)
    );

    always #5 clk = ~clk;

    // Backing memory: byte at address i is i[7:0], one clk of read latency.
    always @(posedge clk) if (mem_rd) mem_rdata <= mem_addr[7:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0h, expected nothing", name, act);
    endtask

    // MISO monitor: master samples on SCK rise while the DUT drives the line.
    logic [7:0] cap = 8'h00;
    int         cap_n = 0;
    always @(posedge spi_sck or posedge spi_cs) begin
        if (spi_cs) cap_n = 0;
        else if (spi_miso_oe === 1'b1) begin
            cap = {cap[6:0], spi_miso};
            cap_n++;
            if (cap_n == 8) begin
                cap_n = 0;
                if (exp_miso.size() == 0) flag("miso_extra_byte", 32'(cap));
                else check("miso_byte", 32'(cap), 32'(exp_miso.pop_front()));
            end
        end
    end

    // Fetch monitor: each strobe must be one clk wide and hit the next expected address.
    logic rd_prev = 1'b0;
    always @(negedge clk) begin
        if (mem_rd === 1'b1) begin
            if (rd_prev) flag("mem_rd_width", 32'(mem_addr));
            if (exp_addr.size() == 0) flag("mem_rd_extra", 32'(mem_addr));
            else check("mem_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
        end
        rd_prev = (mem_rd === 1'b1);
    end

    task automatic sck_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = val[i];
            repeat (4) @(negedge clk);
            spi_sck = 1'b1;
            repeat (4) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        spi_cs = 1'b1;
        repeat (3) @(negedge clk);
        check("oe_after_cs_rise", 32'(spi_miso_oe), 32'd0);
        repeat (6) @(negedge clk);
    endtask

    // Command-level model: expected bytes/fetches follow directly from the command table.
    task automatic txn(input logic [7:0] cmd, input logic [23:0] addr, input int nbytes);
        bit          known;
        logic [23:0] a;
        logic [23:0] id_sh;
        known = !(model_pd && cmd != 8'hAB);
        if (known) begin
            case (cmd)
                8'h03, 8'h0B: begin
                    for (int i = 0; i <= nbytes; i++) begin
                        a = addr + 24'(i);
                        exp_addr.push_back(a);
                        if (i < nbytes) exp_miso.push_back(a[7:0]);
                    end
                end
                8'h9F: for (int i = 0; i < nbytes; i++) begin
                    id_sh = JEDEC >> (8 * (2 - i));
                    exp_miso.push_back(i < 3 ? id_sh[7:0] : 8'hFF);
                end
                8'h05: for (int i = 0; i < nbytes; i++) exp_miso.push_back(STATUS);
                8'hB9: model_pd = 1'b1;
                8'hAB: model_pd = 1'b0;
                default: ;
            endcase
        end
        cs_low();
        sck_bits(32'(cmd), 8);
        if (cmd == 8'h03 || cmd == 8'h0B) sck_bits(32'(addr), 24);
        if (cmd == 8'h0B) sck_bits($urandom, 8);
        for (int i = 0; i < nbytes; i++) sck_bits($urandom, 8);
        cs_high();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_pd = 1'b0;
    endtask

    logic [7:0]  cmds [7] = '{8'h03, 8'h0B, 8'h9F, 8'h05, 8'hB9, 8'hAB, 8'h00};
    logic [7:0]  rc;
    logic [23:0] ra;

    initial begin
        resetn = 1'b0; spi_sck = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0; model_pd = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_oe", 32'(spi_miso_oe), 32'd0);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_powered_down", 32'(powered_down), 32'd0);
        resetn = 1'b1;
        repeat (6) @(negedge clk);

        txn(8'h9F, 24'h0, 5);
        txn(8'h03, 24'h001000, 3);
        txn(8'h0B, 24'hFFFFFF, 2);

        txn(8'hB9, 24'h0, 0);
        check("pd_after_b9", 32'(powered_down), 32'd1);
        txn(8'h9F, 24'h0, 2);
        txn(8'h03, 24'h123456, 2);
        txn(8'hAB, 24'h0, 0);
        check("pd_after_ab", 32'(powered_down), 32'd0);
        txn(8'h9F, 24'h0, 1);

        // Abort a read after 13 address bits.
        cs_low();
        sck_bits(32'h03, 8);
        sck_bits(32'(24'h001000 >> 11), 13);
        cs_high();
        txn(8'h05, 24'h0, 2);

        // Reset clears the power-down flag.
        txn(8'hB9, 24'h0, 0);
        pulse_reset();
        check("pd_after_reset", 32'(powered_down), 32'd0);
        repeat (4) @(negedge clk);

        // Reset mid-DATA, with CS still low afterwards.
        ra = 24'h00ABCD;
        exp_addr.push_back(ra);
        exp_addr.push_back(ra + 24'd1);
        exp_miso.push_back(ra[7:0]);
        cs_low();
        sck_bits(32'h03, 8);
        sck_bits(32'(ra), 24);
        sck_bits($urandom, 8);
        sck_bits($urandom, 3);
        pulse_reset();
        check("midrst_miso", 32'(spi_miso), 32'd0);
        check("midrst_oe", 32'(spi_miso_oe), 32'd0);
        check("midrst_mem_rd", 32'(mem_rd), 32'd0);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        check("midrst_pd", 32'(powered_down), 32'd0);
        sck_bits(32'h9F, 8);
        sck_bits($urandom, 8);
        check("midrst_oe_held", 32'(spi_miso_oe), 32'd0);
        cs_high();
        txn(8'h9F, 24'h0, 3);

        for (int t = 0; t < 20; t++) begin
            rc = cmds[$urandom_range(0, 6)];
            if (rc == 8'h00) rc = 8'($urandom);
            ra = 24'($urandom);
            if ($urandom_range(0, 3) == 0) ra = 24'hFFFFFE;
            txn(rc, ra, $urandom_range(1, 4));
        end
        txn(8'hAB, 24'h0, 0);
        txn(8'h0B, 24'h7FFFFF, 2);

        repeat (20) @(negedge clk);
        check("miso_queue_drained", 32'(exp_miso.size()), 32'd0);
        check("fetch_queue_drained", 32'(exp_addr.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
